// File: rtl/mem_stage_access_ctrl.sv
// mem_stage_access_ctrl: MEM-stage data-memory access sequencer (valid/ready request, response, load format).
// Latency: minimum 3 stall cycles (IDLE, REQ, WAIT) followed by one non-stalled DONE cycle.
// Backpressure: holds stall_out while a request waits for ready or a response; optional MISALIGN_CHECK_EN.
`timescale 1ns/1ps
module mem_stage_access_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [1:0]  mem_read_in,
  input  logic [1:0]  mem_write_in,
  input  logic [31:0] inst_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  output logic        stall_out,
  output logic [31:0] load_data_out,
  output logic        load_valid_out,
  output logic        bus_err_out,
  output logic        misalign_out,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_we,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wstrb,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic             we_q, we_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic [1:0]       size_q, size_d;
  logic             zext_q, zext_d;
  logic             is_load_q, is_load_d;
  logic [31:0]      load_data_q, load_data_d;

  logic             acc;
  logic             is_store;
  logic [CNT_W-1:0] cnt_inc;
  logic             timeout_hit;
  logic             bus_err;
  logic [3:0]       st_strb;
  logic [31:0]      st_data;
  logic [31:0]      rd_shift;
  logic [31:0]      rd_fmt;
  logic             unused_inst;

`ifdef MISALIGN_CHECK_EN
  logic             misalign_q, misalign_d;
  logic             mis_acc;
`endif

  // Only funct3 of the instruction word matters here.
  assign unused_inst = ^{inst_in[31:15], inst_in[11:0]};

  // Access request qualification and store lane steering from the live EX/MEM fields.
  always_comb begin
    acc      = ((mem_read_in != 2'b00) || (mem_write_in != 2'b00)) && !flush;
    is_store = (mem_write_in != 2'b00);
    st_strb  = 4'b1111;
    st_data  = wdata_in;
    case (inst_in[13:12])
      2'b00: begin
        st_strb = 4'b0001 << addr_in[1:0];
        st_data = {4{wdata_in[7:0]}};
      end
      2'b01: begin
        st_strb = 4'b0011 << {addr_in[1], 1'b0};
        st_data = {2{wdata_in[15:0]}};
      end
      default: begin
        st_strb = 4'b1111;
        st_data = wdata_in;
      end
    endcase
`ifdef MISALIGN_CHECK_EN
    mis_acc = ((inst_in[13:12] == 2'b01) && addr_in[0]) ||
              (inst_in[13] && (addr_in[1:0] != 2'b00));
`endif
  end

  // Load formatting: shift the addressed byte to bit 0, then extend by size.
  always_comb begin
    rd_shift = mem_resp_rdata >> {addr_q[1:0], 3'b000};
    rd_fmt   = rd_shift;
    case (size_q)
      2'b00:   rd_fmt = zext_q ? {24'h0, rd_shift[7:0]}  : {{24{rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   rd_fmt = zext_q ? {16'h0, rd_shift[15:0]} : {{16{rd_shift[15]}}, rd_shift[15:0]};
      default: rd_fmt = rd_shift;
    endcase
  end

  // Next-state logic: sequence IDLE->REQ->WAIT->DONE, with DRAIN absorbing responses of flushed ops.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    size_d      = size_q;
    zext_d      = zext_q;
    is_load_d   = is_load_q;
    load_data_d = load_data_q;
    bus_err     = 1'b0;
    cnt_inc     = cnt_q + 1'b1;
    timeout_hit = (TIMEOUT != 0) && (cnt_inc == TO_CNT);
`ifdef MISALIGN_CHECK_EN
    misalign_d  = misalign_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (acc) begin
          addr_d    = addr_in;
          we_d      = is_store;
          wdata_d   = is_store ? st_data : 32'h0;
          wstrb_d   = is_store ? st_strb : 4'b0000;
          size_d    = inst_in[13:12];
          zext_d    = inst_in[14];
          is_load_d = !is_store;
          state_d   = S_REQ;
`ifdef MISALIGN_CHECK_EN
          if (mis_acc) begin
            state_d    = S_DONE;
            misalign_d = 1'b1;
            if (!is_store) load_data_d = 32'h0;
          end
`endif
        end
      end
      S_REQ: begin
        if (mem_req_ready) cnt_d = '0;
        if (flush) begin
          state_d = mem_req_ready ? S_DRAIN : S_IDLE;
        end else if (mem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_inc;
        if (mem_resp_valid) begin
          // A response arriving with the flush completes the bus side; nothing left to drain.
          state_d = flush ? S_IDLE : S_DONE;
          if (is_load_q && !flush) load_data_d = rd_fmt;
        end else if (timeout_hit) begin
          bus_err = 1'b1;
          state_d = flush ? S_IDLE : S_DONE;
          if (is_load_q && !flush) load_data_d = 32'h0;
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
`ifdef MISALIGN_CHECK_EN
        misalign_d = 1'b0;
`endif
      end
      S_DRAIN: begin
        cnt_d = cnt_inc;
        if (mem_resp_valid) begin
          state_d = S_IDLE;
        end else if (timeout_hit) begin
          bus_err = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and captured access registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= 32'h0;
      we_q        <= 1'b0;
      wdata_q     <= 32'h0;
      wstrb_q     <= 4'b0000;
      size_q      <= 2'b00;
      zext_q      <= 1'b0;
      is_load_q   <= 1'b0;
      load_data_q <= 32'h0;
`ifdef MISALIGN_CHECK_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      size_q      <= size_d;
      zext_q      <= zext_d;
      is_load_q   <= is_load_d;
      load_data_q <= load_data_d;
`ifdef MISALIGN_CHECK_EN
      misalign_q  <= misalign_d;
`endif
    end
  end

  // Outputs decoded from registered state; IDLE stall follows the incoming access immediately.
  always_comb begin
    stall_out      = (state_q == S_IDLE) ? acc : (state_q != S_DONE);
    mem_req_valid  = (state_q == S_REQ);
    mem_req_we     = we_q;
    mem_req_addr   = {addr_q[31:2], 2'b00};
    mem_req_wdata  = wdata_q;
    mem_req_wstrb  = wstrb_q;
    load_data_out  = load_data_q;
    load_valid_out = (state_q == S_DONE) && is_load_q && !flush;
    bus_err_out    = bus_err;
`ifdef MISALIGN_CHECK_EN
    misalign_out   = (state_q == S_DONE) && misalign_q;
`else
    misalign_out   = 1'b0;
`endif
  end

endmodule

// File: tb/tb_mem_stage_access_ctrl.sv
// tb_mem_stage_access_ctrl: table vectors, directed multi-cycle sequences and randomized accesses.
// Latency: drives one access at a time and waits on stall_out with a bounded cycle budget.
// Backpressure: the bench plays the memory, delaying ready and response by per-access amounts.
`timescale 1ns/1ps
module tb_mem_stage_access_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [1:0]  mem_read_in, mem_write_in;
  logic [31:0] inst_in, addr_in, wdata_in;
  logic        stall_out, load_valid_out, bus_err_out, misalign_out;
  logic [31:0] load_data_out;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;

  int tests = 0;
  int fails = 0;
  logic [31:0] last_ld = 32'h0;

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          rdy_lat;
    int          rsp_lat;
    logic [3:0]  wstrb;
    logic [31:0] wd;
    logic [31:0] ld;
    int          stall;
    logic        berr;
    logic        mis;
  } vec_t;

  mem_stage_access_ctrl #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .inst_in(inst_in), .addr_in(addr_in), .wdata_in(wdata_in),
    .stall_out(stall_out), .load_data_out(load_data_out),
    .load_valid_out(load_valid_out), .bus_err_out(bus_err_out),
    .misalign_out(misalign_out),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input int rdy, input int rsp, input logic [3:0] wstrb,
                              input logic [31:0] wd, input logic [31:0] ld, input int stall,
                              input logic berr);
    vec_t v;
    v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.rdy_lat = rdy; v.rsp_lat = rsp; v.wstrb = wstrb; v.wd = wd; v.ld = ld;
    v.stall = stall; v.berr = berr; v.mis = 1'b0;
    return v;
  endfunction

  // Reference: bytes touched, lane replication and extension computed arithmetically.
  function automatic vec_t model(input vec_t vi);
    vec_t v;
    int nb, lane0, a;
    logic [31:0] r, mask, val;
    v = vi;
    a = int'(vi.addr[1:0]);
    nb = (vi.f3[1:0] == 2'd0) ? 1 : (vi.f3[1:0] == 2'd1) ? 2 : 4;
    lane0 = (nb == 1) ? a : (nb == 2) ? (a / 2) * 2 : 0;
    v.wstrb = 4'h0;
    v.wd = 32'h0;
    if (vi.st) begin
      for (int i = 0; i < nb; i++) v.wstrb[lane0 + i] = 1'b1;
      for (int l = 0; l < 4; l++) v.wd[8*l +: 8] = vi.wdata[8*(l % nb) +: 8];
    end
    r = vi.rdata >> (8 * a);
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
    val = r & mask;
    if (nb < 4 && !vi.f3[2] && r[8*nb-1]) val = val | ~mask;
    v.berr = (vi.rsp_lat < 1) || (vi.rsp_lat > TO);
    v.stall = 2 + vi.rdy_lat + (v.berr ? TO : vi.rsp_lat);
    v.ld = v.berr ? 32'h0 : val;
    v.mis = 1'b0;
`ifdef MISALIGN_CHECK_EN
    if ((nb == 2 && a % 2 == 1) || (nb == 4 && a != 0)) begin
      v.mis = 1'b1; v.stall = 1; v.ld = 32'h0; v.berr = 1'b0;
    end
`endif
    return v;
  endfunction

  task automatic run_op(input vec_t v, input string nm);
    int req_k = 0, wait_k = 0, stalls = 0, nreq = 0, nerr = 0, err_k = 0, nmis = 0;
    bit accepted = 0, done = 0, unstable = 0;
    logic lv = 1'b0;
    logic [31:0] ld = 32'h0, c_addr = 32'h0, c_wdata = 32'h0;
    logic c_we = 1'b0;
    logic [3:0] c_strb = 4'h0;
    mem_read_in  = v.st ? 2'b00 : 2'b01;
    mem_write_in = v.st ? 2'b01 : 2'b00;
    inst_in      = 32'h0000_0003 | ({29'h0, v.f3} << 12);
    addr_in      = v.addr;
    wdata_in     = v.wdata;
    mem_resp_rdata = v.rdata;
    for (int c = 0; c < 60 && !done; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
        if (accepted) begin
          wait_k++;
          if (wait_k == v.rsp_lat) mem_resp_valid = 1'b1;
        end else if (mem_req_valid) begin
          if (req_k == v.rdy_lat) begin
            mem_req_ready = 1'b1;
            accepted = 1;
          end
          req_k++;
        end
      end
      @(negedge clk);
      if (bus_err_out) begin nerr++; err_k = wait_k; end
      if (misalign_out) nmis++;
      if (mem_req_valid) begin
        if (nreq == 0) begin
          c_addr = mem_req_addr; c_we = mem_req_we; c_strb = mem_req_wstrb; c_wdata = mem_req_wdata;
        end else if (c_addr !== mem_req_addr || c_we !== mem_req_we ||
                     c_strb !== mem_req_wstrb || c_wdata !== mem_req_wdata) begin
          unstable = 1;
        end
        nreq++;
      end
      if (stall_out) stalls++;
      else begin
        done = 1; lv = load_valid_out; ld = load_data_out;
      end
    end
    chk({nm, ".completed"}, 32'(done), 32'd1);
    chk({nm, ".stall_cycles"}, 32'(stalls), 32'(v.stall));
    chk({nm, ".req_issued"}, 32'(nreq > 0), 32'(!v.mis));
    if (nreq > 0) begin
      chk({nm, ".req_stable"}, 32'(unstable), 32'd0);
      chk({nm, ".req_addr"}, c_addr, {v.addr[31:2], 2'b00});
      chk({nm, ".req_we"}, 32'(c_we), 32'(v.st));
      chk({nm, ".req_wstrb"}, 32'(c_strb), 32'(v.wstrb));
      if (v.st) chk({nm, ".req_wdata"}, c_wdata, v.wd);
    end
    chk({nm, ".load_valid"}, 32'(lv), 32'(!v.st));
    chk({nm, ".load_data"}, ld, v.st ? last_ld : v.ld);
    if (!v.st) last_ld = v.ld;
    chk({nm, ".bus_err_pulses"}, 32'(nerr), 32'(v.berr));
    if (v.berr) chk({nm, ".bus_err_cycle"}, 32'(err_k), 32'(TO));
    chk({nm, ".misalign_pulses"}, 32'(nmis), 32'(v.mis));
    @(posedge clk); #1;
    mem_read_in = 2'b00; mem_write_in = 2'b00;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [12];
    vec_t v;
    rst = 1'b0; flush = 1'b0;
    mem_read_in = 2'b00; mem_write_in = 2'b00;
    inst_in = 32'h0; addr_in = 32'h0; wdata_in = 32'h0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = 32'h0;

    //           st    f3      addr        wdata         rdata         rdy rsp wstrb  wd            ld            stall berr
    tbl[0]  = mk(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        0, 2, 4'hF, 32'hDEADBEEF, 32'h0,        4, 1'b0);
    tbl[1]  = mk(1'b0, 3'b000, 32'h103, 32'h0,        32'h80FF0011, 0, 1, 4'h0, 32'h0,        32'hFFFFFF80, 3, 1'b0);
    tbl[2]  = mk(1'b0, 3'b100, 32'h103, 32'h0,        32'h80FF0011, 0, 1, 4'h0, 32'h0,        32'h00000080, 3, 1'b0);
    tbl[3]  = mk(1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0,        1, 1, 4'hC, 32'hABCDABCD, 32'h0,        4, 1'b0);
    tbl[4]  = mk(1'b0, 3'b001, 32'h102, 32'h0,        32'h80015678, 0, 2, 4'h0, 32'h0,        32'hFFFF8001, 4, 1'b0);
    tbl[5]  = mk(1'b0, 3'b010, 32'h104, 32'h0,        32'h12345678, 2, 3, 4'h0, 32'h0,        32'h12345678, 7, 1'b0);
    tbl[6]  = mk(1'b0, 3'b101, 32'h100, 32'h0,        32'h0000F00D, 0, 1, 4'h0, 32'h0,        32'h0000F00D, 3, 1'b0);
    tbl[7]  = mk(1'b1, 3'b000, 32'h101, 32'h000000AB, 32'h0,        0, 1, 4'h2, 32'hABABABAB, 32'h0,        3, 1'b0);
    tbl[8]  = mk(1'b0, 3'b010, 32'h108, 32'h0,        32'hCAFEF00D, 0, 0, 4'h0, 32'h0,        32'h0,        6, 1'b1);
    tbl[9]  = mk(1'b1, 3'b010, 32'h10C, 32'h11223344, 32'h0,        1, 0, 4'hF, 32'h11223344, 32'h0,        7, 1'b1);
    tbl[10] = mk(1'b0, 3'b000, 32'h100, 32'h0,        32'h0000007F, 0, 1, 4'h0, 32'h0,        32'h0000007F, 3, 1'b0);
    tbl[11] = mk(1'b0, 3'b011, 32'h108, 32'h0,        32'hA5A50F0F, 0, 1, 4'h0, 32'h0,        32'hA5A50F0F, 3, 1'b0);

    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.stall", 32'(stall_out), 32'd0);
    chk("rst.req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst.load_valid", 32'(load_valid_out), 32'd0);
    chk("rst.load_data", load_data_out, 32'h0);
    chk("rst.bus_err", 32'(bus_err_out), 32'd0);
    chk("rst.misalign", 32'(misalign_out), 32'd0);
    chk("rst.wstrb", 32'(mem_req_wstrb), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < 12; i++) run_op(tbl[i], $sformatf("vec%0d", i));

    // A response while idle must be ignored.
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h5555AAAA;
    @(negedge clk);
    chk("stray_resp.load_valid", 32'(load_valid_out), 32'd0);
    chk("stray_resp.stall", 32'(stall_out), 32'd0);
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    @(negedge clk);
    chk("stray_resp.load_data", load_data_out, last_ld);
    @(posedge clk); #1;

    // Flush in WAIT: drain a late response, no load reported.
    mem_read_in = 2'b01; inst_in = 32'h0000_2003; addr_in = 32'h200; mem_resp_rdata = 32'h0BAD0BAD;
    @(negedge clk);
    chk("fl_wait.idle_stall", 32'(stall_out), 32'd1);
    @(posedge clk); #1;
    mem_req_ready = 1'b1;
    @(negedge clk);
    chk("fl_wait.req_valid", 32'(mem_req_valid), 32'd1);
    @(posedge clk); #1;
    mem_req_ready = 1'b0; flush = 1'b1; mem_read_in = 2'b00;
    @(negedge clk);
    chk("fl_wait.wait_stall", 32'(stall_out), 32'd1);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      flush = 1'b0;
      mem_resp_valid = (k == 3);
      @(negedge clk);
      chk($sformatf("fl_wait.drain_stall%0d", k), 32'(stall_out), 32'd1);
      chk($sformatf("fl_wait.drain_lv%0d", k), 32'(load_valid_out), 32'd0);
      chk($sformatf("fl_wait.drain_berr%0d", k), 32'(bus_err_out), 32'd0);
    end
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    @(negedge clk);
    chk("fl_wait.idle_stall_after", 32'(stall_out), 32'd0);
    chk("fl_wait.load_valid_after", 32'(load_valid_out), 32'd0);
    chk("fl_wait.load_data_held", load_data_out, last_ld);
    @(posedge clk); #1;

    // Flush in REQ without ready: valid drops, back to IDLE.
    mem_write_in = 2'b01; inst_in = 32'h0000_2023; addr_in = 32'h300; wdata_in = 32'h77777777;
    @(posedge clk); #1;
    flush = 1'b1; mem_write_in = 2'b00;
    @(negedge clk);
    chk("fl_req.valid_in_req", 32'(mem_req_valid), 32'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("fl_req.valid_dropped", 32'(mem_req_valid), 32'd0);
    chk("fl_req.stall", 32'(stall_out), 32'd0);
    @(posedge clk); #1;

    // Asynchronous reset while waiting for a response.
    mem_read_in = 2'b01; inst_in = 32'h0000_2003; addr_in = 32'h400;
    @(posedge clk); #1;
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    @(negedge clk);
    chk("rst_wait.stall_before", 32'(stall_out), 32'd1);
    rst = 1'b0; mem_read_in = 2'b00;
    #1;
    chk("rst_wait.stall", 32'(stall_out), 32'd0);
    chk("rst_wait.req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_wait.load_data", load_data_out, 32'h0);
    last_ld = 32'h0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

`ifdef MISALIGN_CHECK_EN
    v = mk(1'b0, 3'b010, 32'h102, 32'h0, 32'h12345678, 0, 1, 4'h0, 32'h0, 32'h0, 1, 1'b0);
    v.mis = 1'b1;
    run_op(v, "misalign_lw");
`endif

    // Randomized accesses against the reference model.
    for (int i = 0; i < 40; i++) begin
      v.st      = 1'($urandom_range(0, 1));
      v.f3      = {v.st ? 1'b0 : 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3))};
      v.addr    = $urandom;
      v.wdata   = $urandom;
      v.rdata   = $urandom;
      v.rdy_lat = $urandom_range(0, 2);
      v.rsp_lat = $urandom_range(1, 6);
      v = model(v);
      run_op(v, $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
